// File: rtl/bank_htu_pkg.sv
// Shared encodings for the HTU bank request sequencer.
package bank_htu_pkg;

    localparam int TAG_W = 22;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FLUSH = 2'd2,
        OP_INV   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_INVALID = 2'b00,
        ST_CLEAN   = 2'b01,
        ST_DIRTY   = 2'b10
    } ofs_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_RF_REQ,
        S_RF_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/bank_htu_mem_port.sv
// Sub-memory handshake shared by writeback and refill: holds the request until
// accepted, then reports the completion seen while waiting.
module bank_htu_mem_port
    import bank_htu_pkg::*;
(
    input  logic        req_phase_i,
    input  logic        wait_phase_i,
    input  logic        is_wb_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  way_i,
    input  logic [1:0]  wmask_i,
    input  logic        mem_req_ready_i,
    input  logic        mem_resp_valid_i,
    output logic        mem_req_valid_o,
    output logic        mem_req_is_wb_o,
    output logic [31:0] mem_req_addr_o,
    output logic [2:0]  mem_req_way_o,
    output logic [1:0]  mem_req_wmask_o,
    output logic        req_done_o,
    output logic        resp_done_o
);

    // Payload comes from fields latched by the sequencer, so it stays stable
    // for as long as the request phase lasts.
    assign mem_req_valid_o = req_phase_i;
    assign mem_req_is_wb_o = req_phase_i && is_wb_i;
    assign mem_req_addr_o  = req_phase_i ? addr_i  : '0;
    assign mem_req_way_o   = req_phase_i ? way_i   : '0;
    assign mem_req_wmask_o = req_phase_i ? wmask_i : '0;

    assign req_done_o  = req_phase_i && mem_req_ready_i;
    assign resp_done_o = wait_phase_i && mem_resp_valid_i;

endmodule

// File: rtl/bank_htu_req_ctrl.sv
// Blocking per-bank request sequencer: set lookup, optional victim writeback and
// refill, then response. Perf counters exist when BANK_HTU_REQ_CTRL_PERF_EN is defined.
module bank_htu_req_ctrl
    import bank_htu_pkg::*;
#(
    parameter int SET_IDX_W = 5,
    parameter int NUM_SETS  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [31:0]          req_addr_i,
    output logic [NUM_SETS-1:0]  set_sel_o,
    output logic                 lookup_o,
    output logic                 op_is_read_o,
    output logic                 op_is_write_o,
    output logic                 op_is_flush_o,
    output logic                 op_is_invalidate_o,
    output logic [TAG_W-1:0]     access_tag_o,
    output logic                 access_offset_o,
    input  logic                 cl_hit_i,
    input  logic                 cl_need_evict_i,
    input  logic [1:0]           cl_offset0_state_i,
    input  logic [1:0]           cl_offset1_state_i,
    input  logic [2:0]           cl_way_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_req_is_wb_o,
    output logic [31:0]          mem_req_addr_o,
    output logic [2:0]           mem_req_way_o,
    output logic [1:0]           mem_req_wmask_o,
    input  logic                 mem_resp_valid_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_hit_o,
    output logic [2:0]           resp_way_o
`ifdef BANK_HTU_REQ_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_hit_cnt_o,
    output logic [31:0]          perf_miss_cnt_o,
    output logic [31:0]          perf_wb_cnt_o
`endif
);

    state_e                 state_q, state_d;
    op_e                    op_q;
    logic [TAG_W-1:0]       tag_q;
    logic [SET_IDX_W-1:0]   set_q;
    logic                   offset_q;
    logic                   hit_q;
    logic [2:0]             way_q;
    logic [1:0]             wmask_q, wmask_d;

    logic        in_lookup, in_wb, req_phase, wait_phase;
    logic        accept, req_done, resp_done, is_rw;
    logic [1:0]  acc_state;
    logic [31:0] wb_addr, rf_addr;
    logic        unused_addr_bits;

    assign in_lookup  = (state_q == S_LOOKUP);
    assign in_wb      = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);
    assign req_phase  = (state_q == S_WB_REQ) || (state_q == S_RF_REQ);
    assign wait_phase = (state_q == S_WB_WAIT) || (state_q == S_RF_WAIT);
    assign is_rw      = (op_q == OP_READ) || (op_q == OP_WRITE);
    assign acc_state  = offset_q ? cl_offset1_state_i : cl_offset0_state_i;

    // Ready is masked by reset so nothing is accepted while the bank is held in reset.
    assign req_ready_o = rst_i && (state_q == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    assign unused_addr_bits = ^req_addr_i[3:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        wmask_d = {cl_offset1_state_i == ST_DIRTY, cl_offset0_state_i == ST_DIRTY};
        unique case (state_q)
            S_IDLE:    if (accept) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (is_rw && !cl_hit_i && cl_need_evict_i) begin
                    state_d = S_WB_REQ;
                end else if (op_q == OP_FLUSH && cl_hit_i && acc_state == ST_DIRTY) begin
                    state_d = S_WB_REQ;
                    wmask_d = offset_q ? 2'b10 : 2'b01;
                end else if (op_q == OP_READ && (!cl_hit_i || acc_state == ST_INVALID)) begin
                    state_d = S_RF_REQ;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WB_REQ:  if (req_done) state_d = S_WB_WAIT;
            // A write miss only needs the victim gone; the write itself fills its offset.
            S_WB_WAIT: if (resp_done) state_d = (op_q == OP_READ) ? S_RF_REQ : S_RESP;
            S_RF_REQ:  if (req_done) state_d = S_RF_WAIT;
            S_RF_WAIT: if (resp_done) state_d = S_RESP;
            S_RESP:    if (resp_ready_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: non-blocking assignments let every flop sample pre-edge values, independent of statement order.
        if (!rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_READ;
            tag_q    <= '0;
            set_q    <= '0;
            offset_q <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            wmask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= op_e'(req_op_i);
                tag_q    <= req_addr_i[31:32-TAG_W];
                set_q    <= req_addr_i[9:10-SET_IDX_W];
                offset_q <= req_addr_i[4];
            end
            if (in_lookup) begin
                hit_q   <= cl_hit_i;
                way_q   <= cl_way_i;
                wmask_q <= wmask_d;
            end
        end
    end

    assign wb_addr = {{TAG_W{1'b0}}, set_q, {(10-SET_IDX_W){1'b0}}};
    assign rf_addr = {tag_q, set_q, offset_q, {(9-SET_IDX_W){1'b0}}};

    bank_htu_mem_port u_mem_port (
        .req_phase_i      (req_phase),
        .wait_phase_i     (wait_phase),
        .is_wb_i          (in_wb),
        .addr_i           (in_wb ? wb_addr : rf_addr),
        .way_i            (way_q),
        .wmask_i          (in_wb ? wmask_q : 2'b00),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_is_wb_o  (mem_req_is_wb_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_way_o    (mem_req_way_o),
        .mem_req_wmask_o  (mem_req_wmask_o),
        .req_done_o       (req_done),
        .resp_done_o      (resp_done)
    );

    assign lookup_o           = in_lookup;
    assign set_sel_o          = in_lookup ? (NUM_SETS'(1) << set_q) : '0;
    assign op_is_read_o       = in_lookup && (op_q == OP_READ);
    assign op_is_write_o      = in_lookup && (op_q == OP_WRITE);
    assign op_is_flush_o      = in_lookup && (op_q == OP_FLUSH);
    assign op_is_invalidate_o = in_lookup && (op_q == OP_INV);
    assign access_tag_o       = tag_q;
    assign access_offset_o    = offset_q;

    assign resp_valid_o = (state_q == S_RESP);
    assign resp_hit_o   = resp_valid_o && hit_q;
    assign resp_way_o   = resp_valid_o ? way_q : '0;

`ifdef BANK_HTU_REQ_CTRL_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (in_lookup && is_rw && cl_hit_i && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (in_lookup && is_rw && !cl_hit_i && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (req_done && in_wb && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
    assign perf_wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_bank_htu_req_ctrl.sv
// Scoreboard bench for bank_htu_req_ctrl: a request-level model predicts lookups,
// sub-memory transactions and responses; a monitor compares what the DUT presents.
module tb_bank_htu_req_ctrl;
    import bank_htu_pkg::*;

    localparam int SET_IDX_W = 5;
    localparam int NUM_SETS  = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic req_valid_i, req_ready_o;
    logic [1:0] req_op_i;
    logic [31:0] req_addr_i;
    logic [NUM_SETS-1:0] set_sel_o;
    logic lookup_o, op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o;
    logic [21:0] access_tag_o;
    logic access_offset_o;
    logic cl_hit_i, cl_need_evict_i;
    logic [1:0] cl_offset0_state_i, cl_offset1_state_i;
    logic [2:0] cl_way_i;
    logic mem_req_valid_o, mem_req_ready_i, mem_req_is_wb_o;
    logic [31:0] mem_req_addr_o;
    logic [2:0] mem_req_way_o;
    logic [1:0] mem_req_wmask_o;
    logic mem_resp_valid_i;
    logic resp_valid_o, resp_ready_i, resp_hit_o;
    logic [2:0] resp_way_o;

    bank_htu_req_ctrl #(.SET_IDX_W(SET_IDX_W), .NUM_SETS(NUM_SETS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i),
        .set_sel_o(set_sel_o), .lookup_o(lookup_o),
        .op_is_read_o(op_is_read_o), .op_is_write_o(op_is_write_o),
        .op_is_flush_o(op_is_flush_o), .op_is_invalidate_o(op_is_invalidate_o),
        .access_tag_o(access_tag_o), .access_offset_o(access_offset_o),
        .cl_hit_i(cl_hit_i), .cl_need_evict_i(cl_need_evict_i),
        .cl_offset0_state_i(cl_offset0_state_i), .cl_offset1_state_i(cl_offset1_state_i),
        .cl_way_i(cl_way_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_is_wb_o(mem_req_is_wb_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_way_o(mem_req_way_o), .mem_req_wmask_o(mem_req_wmask_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_way_o(resp_way_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_wb;
        logic [31:0] addr;
        logic [2:0]  way;
        logic [1:0]  wmask;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] sel;
        logic [3:0]  ops;   // {inv, flush, write, read}
        logic [21:0] tag;
        logic        ofs;
    } lk_exp_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    lk_exp_t  exp_lk[$];
    rsp_exp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;
    bit hold_ready_low = 1'b0;
    bit no_resp = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an output with no expectation pending, expected none (t=%0t)", name, $time);
    endtask

    function automatic logic [63:0] ctl_vec();
        return 64'({req_ready_o, set_sel_o, lookup_o, op_is_invalidate_o, op_is_flush_o,
                    op_is_write_o, op_is_read_o, access_tag_o, access_offset_o});
    endfunction

    function automatic logic [63:0] data_vec();
        return 64'({mem_req_valid_o, mem_req_is_wb_o, mem_req_addr_o, mem_req_way_o,
                    mem_req_wmask_o, resp_valid_o, resp_hit_o, resp_way_o});
    endfunction

    // Request-level reference: what one request must produce, from the bank's rules.
    task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                         input logic evict, input logic [1:0] o0, input logic [1:0] o1,
                         input logic [2:0] way, output int n_mem);
        lk_exp_t  lk;
        mem_exp_t m;
        rsp_exp_t r;
        logic [1:0] acc;
        bit rw, wb, rf;
        acc = addr[4] ? o1 : o0;
        rw  = (op == 2'd0) || (op == 2'd1);
        lk.sel = 32'd1 << addr[9:5];
        lk.ops = 4'd1 << op;
        lk.tag = addr[31:10];
        lk.ofs = addr[4];
        exp_lk.push_back(lk);
        n_mem = 0;
        wb = 1'b0;
        m.way = way;
        m.is_wb = 1'b1;
        m.addr = addr & 32'h0000_03E0;
        if (rw && !hit && evict) begin
            wb = 1'b1;
            m.wmask = {o1 == 2'b10, o0 == 2'b10};
        end else if (op == 2'd2 && hit && acc == 2'b10) begin
            wb = 1'b1;
            m.wmask = addr[4] ? 2'b10 : 2'b01;
        end
        if (wb) begin
            exp_mem.push_back(m);
            n_mem++;
        end
        rf = (op == 2'd0) && (!hit || acc == 2'b00);
        if (rf) begin
            m.is_wb = 1'b0;
            m.addr = addr & 32'hFFFF_FFF0;
            m.wmask = 2'b00;
            exp_mem.push_back(m);
            n_mem++;
        end
        r.hit = hit;
        r.way = way;
        exp_rsp.push_back(r);
    endtask

    // Monitor: pops and compares whenever the DUT presents a lookup, mem handshake or response.
    initial begin
        mem_exp_t prev, cur, em;
        lk_exp_t  el, gl;
        rsp_exp_t er, gr;
        bit prev_v, prev_hs;
        prev_v = 1'b0;
        prev_hs = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev_v = 1'b0;
                continue;
            end
            if (lookup_o) begin
                gl = {set_sel_o, op_is_invalidate_o, op_is_flush_o, op_is_write_o, op_is_read_o,
                      access_tag_o, access_offset_o};
                if (exp_lk.size() == 0) fail_now("lookup_unexpected");
                else begin
                    el = exp_lk.pop_front();
                    check("lookup", 64'(gl), 64'(el));
                end
            end
            cur = {mem_req_is_wb_o, mem_req_addr_o, mem_req_way_o, mem_req_wmask_o};
            if (mem_req_valid_o) begin
                if (prev_v && !prev_hs) check("mem_req_stable", 64'(cur), 64'(prev));
                if (mem_req_ready_i) begin
                    if (exp_mem.size() == 0) fail_now("mem_req_unexpected");
                    else begin
                        em = exp_mem.pop_front();
                        check("mem_req", 64'(cur), 64'(em));
                    end
                end
            end
            prev_v  = mem_req_valid_o;
            prev_hs = mem_req_valid_o && mem_req_ready_i;
            prev    = cur;
            if (resp_valid_o && resp_ready_i) begin
                gr = {resp_hit_o, resp_way_o};
                if (exp_rsp.size() == 0) fail_now("resp_unexpected");
                else begin
                    er = exp_rsp.pop_front();
                    check("resp", 64'(gr), 64'(er));
                end
            end
        end
    end

    // Sub-memory responder: random ready, completion 1..4 cycles after each accepted request.
    initial begin
        int pend;
        bit hs;
        pend = 0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        forever begin
            @(negedge clk_i);
            hs = rst_i && mem_req_valid_o && mem_req_ready_i;
            @(posedge clk_i);
            #1;
            mem_resp_valid_i = 1'b0;
            if (!rst_i) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0 && !no_resp) mem_resp_valid_i = 1'b1;
            end
            if (hs && rst_i) pend = $urandom_range(1, 4);
            mem_req_ready_i = hold_ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the response handshake.
    task automatic do_txn(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                          input logic evict, input logic [1:0] o0, input logic [1:0] o1,
                          input logic [2:0] way, input int rstall, input bit hold_mem);
        int n_mem, t_hs;
        bit ok;
        model(op, addr, hit, evict, o0, o1, way, n_mem);
        cl_hit_i = hit;
        cl_need_evict_i = evict;
        cl_offset0_state_i = o0;
        cl_offset1_state_i = o1;
        cl_way_i = way;
        hold_ready_low = hold_mem;
        req_valid_i = 1'b1;
        req_op_i = op;
        req_addr_i = addr;
        @(negedge clk_i);
        check("b2b_ready", 64'(req_ready_o), 64'd1);
        ok = req_ready_o;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk_i);
            ok = req_ready_o;
        end
        t_hs = cyc;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_op_i = 2'($urandom);
        req_addr_i = $urandom;
        if (hold_mem) begin
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk_i);
                ok = mem_req_valid_o;
            end
            check("mem_req_appears", 64'(ok), 64'd1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk_i);
                check("mem_req_held_valid", 64'(mem_req_valid_o), 64'd1);
            end
            @(posedge clk_i);
            #1;
            hold_ready_low = 1'b0;
        end
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk_i);
            ok = resp_valid_o;
        end
        check("resp_within_budget", 64'(ok), 64'd1);
        if (ok && n_mem == 0 && !hold_mem) check("resp_latency", 64'(cyc - t_hs), 64'd2);
        for (int k = 0; k < rstall; k++) begin
            check("resp_held", 64'({resp_valid_o, req_ready_o}), 64'b10);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
    endtask

    initial begin
        int n_mem;
        bit ok;
        req_valid_i = 1'b0;
        req_op_i = '0;
        req_addr_i = '0;
        cl_hit_i = 1'b0;
        cl_need_evict_i = 1'b0;
        cl_offset0_state_i = '0;
        cl_offset1_state_i = '0;
        cl_way_i = '0;
        resp_ready_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check("reset_ctl", ctl_vec(), 64'd0);
        check("reset_data", data_vec(), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("release_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Directed cases: op, addr, hit, evict, off0, off1, way, resp stall, hold mem ready.
        do_txn(2'd0, 32'hABCD_E2A0, 1'b1, 1'b0, 2'b01, 2'b00, 3'd5, 0, 1'b0);
        do_txn(2'd0, 32'h1234_5770, 1'b0, 1'b1, 2'b10, 2'b01, 3'd3, 0, 1'b0);
        do_txn(2'd1, 32'h0F0F_0140, 1'b0, 1'b0, 2'b00, 2'b00, 3'd6, 0, 1'b0);
        do_txn(2'd2, 32'hFFFF_FFF0, 1'b1, 1'b0, 2'b01, 2'b10, 3'd1, 0, 1'b0);
        do_txn(2'd2, 32'h8000_0000, 1'b1, 1'b1, 2'b01, 2'b10, 3'd2, 0, 1'b0);
        do_txn(2'd1, 32'h5555_53E0, 1'b0, 1'b1, 2'b10, 2'b10, 3'd7, 3, 1'b1);
        do_txn(2'd3, 32'h2468_ACE0, 1'b1, 1'b1, 2'b10, 2'b10, 3'd4, 1, 1'b0);
        do_txn(2'd0, 32'hDEAD_BE10, 1'b1, 1'b0, 2'b10, 2'b00, 3'd0, 0, 1'b0);

        // Reset while the refill is outstanding.
        no_resp = 1'b1;
        model(2'd0, 32'hCAFE_0330, 1'b0, 1'b0, 2'b00, 2'b00, 3'd2, n_mem);
        cl_hit_i = 1'b0;
        cl_need_evict_i = 1'b0;
        cl_offset0_state_i = 2'b00;
        cl_offset1_state_i = 2'b00;
        cl_way_i = 3'd2;
        req_valid_i = 1'b1;
        req_op_i = 2'd0;
        req_addr_i = 32'hCAFE_0330;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = mem_req_valid_o && mem_req_ready_i;
        end
        check("rf_before_reset", 64'(ok), 64'd1);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        check("midrun_reset_ctl", ctl_vec(), 64'd0);
        check("midrun_reset_data", data_vec(), 64'd0);
        exp_lk.delete();
        exp_mem.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        no_resp = 1'b0;
        @(negedge clk_i);
        check("post_reset_idle", 64'({req_ready_o, mem_req_valid_o, resp_valid_o}), 64'b100);
        @(posedge clk_i);
        #1;
        do_txn(2'd0, 32'h0000_0010, 1'b0, 1'b1, 2'b01, 2'b10, 3'd5, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            do_txn(2'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom),
                   2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 3'($urandom),
                   $urandom_range(0, 2), 1'b0);
        end

        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", 64'(exp_lk.size() + exp_mem.size() + exp_rsp.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at t=%0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
